// File: rtl/fifo_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | fifo_pkg : shared pointer/occupancy helpers for the FIFO read side       |
// | Revision : 1.0                                                           |
// +-------------------------------------------------------------------------+
package fifo_pkg;

  localparam int MIN_DEPTH = 2;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_buf.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | fifo_rd_stream_buf : DEPTH-entry ring buffer with push/pop/occupancy     |
// | Revision : 1.0                                                           |
// +-------------------------------------------------------------------------+
module fifo_rd_stream_buf
  import fifo_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 3,
  localparam int PW   = ptr_width(DEPTH),
  localparam int OW   = occ_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [OW-1:0]   occ,
  output logic [BITS-1:0] head_data
);

  if (DEPTH < MIN_DEPTH) begin : g_depth_check
    $error("fifo_rd_stream_buf: DEPTH must be at least 2");
  end

  logic [BITS-1:0] mem_q [DEPTH];
  logic [BITS-1:0] mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            pop_ok;

  always_comb begin
    pop_ok = pop && (occ_q != '0);
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = PW'(ptr_inc(32'(tail_q), 32'(DEPTH)));
    end
    if (pop_ok) begin
      head_d = PW'(ptr_inc(32'(head_q), 32'(DEPTH)));
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop_ok})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | fifo_rd_stream : async-FIFO read port to valid/ready stream adapter      |
// | Optional: define FIFO_RD_STREAM_CNT_EN for the beat_cnt output port.    |
// | Revision : 1.0                                                           |
// +-------------------------------------------------------------------------+
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 3
) (
  input  logic            rd_clk,
  input  logic            rd_rst_n,
  output logic            fifo_rd_en,
  input  logic [BITS-1:0] fifo_rd_data,
  input  logic            fifo_rd_empty,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]     beat_cnt
`endif
);

  localparam int OW = occ_width(DEPTH);
  localparam logic [OW:0] DEPTH_W = (OW+1)'(DEPTH);

  logic [OW-1:0] occ;
  logic          inflight_q, inflight_d;
  logic          handshake;

  // Request only from registered state, reserving a slot for every word in flight.
  always_comb begin
    fifo_rd_en = !fifo_rd_empty && (((OW+1)'(occ) + (OW+1)'(inflight_q)) < DEPTH_W);
    inflight_d = fifo_rd_en;
    m_valid    = (occ != '0);
    handshake  = m_valid && m_ready;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) inflight_q <= 1'b0;
    else           inflight_q <= inflight_d;
  end

  fifo_rd_stream_buf #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (handshake),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb beat_cnt_d = beat_cnt_q + 32'(handshake);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) beat_cnt_q <= '0;
    else           beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
`default_nettype wire
